cdown_timer: RTL and testbench

//  mm:ss countdown timer: the count-down counterpart of the stopwatch's up-counting mod-60 pairs.

---
 rtl/cdt_pkg.sv | 15 +
 rtl/dcnt60.sv | 46 ++++
 rtl/cdown_timer.sv | 168 ++++++++++++++++
 tb/tb_cdown_timer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cdt_pkg.sv
// Shared definitions for the mm:ss countdown timer: FSM state encoding and
// BCD digit limits used by the mod-60 digit pairs.
package cdt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX  = 3'd5;

endpackage

// File: rtl/dcnt60.sv
// Mod-60 BCD digit pair (3-bit tens, 4-bit units) with parallel load,
// up count and down count. Load has priority over INC, INC over DEC.
// BO flags a borrow out of 00 so a higher pair can be chained on it.
module dcnt60
  import cdt_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       LD,
  input  logic [2:0] LDH,
  input  logic [3:0] LDL,
  input  logic       INC,
  input  logic       DEC,
  output logic [2:0] QH,
  output logic [3:0] QL,
  output logic       BO
);

  // Digit pair register: load, mod-60 increment or decrement with borrow.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      QH <= 3'd0;
      QL <= 4'd0;
    end else if (LD) begin
      QH <= LDH;
      QL <= LDL;
    end else if (INC) begin
      if (QL == UNITS_MAX) begin
        QL <= 4'd0;
        QH <= (QH == TENS_MAX) ? 3'd0 : QH + 3'd1;
      end else begin
        QL <= QL + 4'd1;
      end
    end else if (DEC) begin
      if (QL == 4'd0) begin
        QL <= UNITS_MAX;
        QH <= (QH == 3'd0) ? TENS_MAX : QH - 3'd1;
      end else begin
        QL <= QL - 4'd1;
      end
    end
  end

  assign BO = (QH == 3'd0) && (QL == 4'd0) && DEC;

endmodule

// File: rtl/cdown_timer.sv
// mm:ss countdown timer with preset buttons, start/pause/clear and an alarm
// that auto-silences after ALARM_SEC ticks.
// Optional feature: define CDT_RESTORE_EN to latch the time at start as a
// preset and reload it into the display when the alarm ends.
module cdown_timer
  import cdt_pkg::*;
#(
  parameter int ALARM_SEC = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN1HZ,
  input  logic       START,
  input  logic       STOP,
  input  logic       CLR,
  input  logic       SET_MIN,
  input  logic       SET_SEC,
  output logic [2:0] MH,
  output logic [3:0] ML,
  output logic [2:0] SH,
  output logic [3:0] SL,
  output logic       RUNNING,
  output logic       BUZZ
);

  state_t     state, state_nxt;
  logic [7:0] alarm_cnt, alarm_cnt_nxt;
  logic       ld;
  logic [2:0] ld_mh, ld_sh;
  logic [3:0] ld_ml, ld_sl;
  logic       sec_inc, min_inc, sec_dec;
  logic       sec_bo, min_bo;
  logic       time_zero, time_one;

  assign time_zero = (MH == 3'd0) && (ML == 4'd0) && (SH == 3'd0) && (SL == 4'd0);
  assign time_one  = (MH == 3'd0) && (ML == 4'd0) && (SH == 3'd0) && (SL == 4'd1);

  // A tick only reaches the counter in RUN when no higher-priority button is pressed.
  assign sec_dec = (state == RUN) && EN1HZ && !CLR && !STOP && !START;

`ifdef CDT_RESTORE_EN
  logic [2:0] pre_mh, pre_sh;
  logic [3:0] pre_ml, pre_sl;

  // Preset capture on IDLE->RUN; CLR wipes it together with the display.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      {pre_mh, pre_ml, pre_sh, pre_sl} <= '0;
    end else if (CLR) begin
      {pre_mh, pre_ml, pre_sh, pre_sl} <= '0;
    end else if (state == IDLE && state_nxt == RUN) begin
      {pre_mh, pre_ml, pre_sh, pre_sl} <= {MH, ML, SH, SL};
    end
  end
`endif

  // State, alarm counter and registered status outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      alarm_cnt <= 8'd0;
      RUNNING   <= 1'b0;
      BUZZ      <= 1'b0;
    end else begin
      state     <= state_nxt;
      alarm_cnt <= alarm_cnt_nxt;
      RUNNING   <= (state_nxt == RUN);
      BUZZ      <= (state_nxt == ALARM);
    end
  end

  // Next-state and digit-control decode with CLR > STOP > START > SET/tick priority.
  always_comb begin
    state_nxt     = state;
    alarm_cnt_nxt = alarm_cnt;
    ld            = 1'b0;
    ld_mh         = 3'd0;
    ld_ml         = 4'd0;
    ld_sh         = 3'd0;
    ld_sl         = 4'd0;
    sec_inc       = 1'b0;
    min_inc       = 1'b0;
    case (state)
      IDLE: begin
        if (CLR) begin
          ld = 1'b1;
        end else if (STOP) begin
          state_nxt = IDLE;
        end else if (START) begin
          if (!time_zero) state_nxt = RUN;
        end else begin
          sec_inc = SET_SEC;
          min_inc = SET_MIN;
        end
      end
      RUN: begin
        if (CLR) begin
          state_nxt = IDLE;
          ld        = 1'b1;
        end else if (STOP) begin
          state_nxt = PAUSE;
        end else if (sec_dec && (time_one || min_bo)) begin
          // Last second expires (min_bo guards against any wrap past 00:00).
          state_nxt     = ALARM;
          alarm_cnt_nxt = 8'd0;
        end
      end
      PAUSE: begin
        if (CLR) begin
          state_nxt = IDLE;
          ld        = 1'b1;
        end else if (STOP) begin
          state_nxt = PAUSE;
        end else if (START) begin
          state_nxt = RUN;
        end
      end
      ALARM: begin
        if (CLR) begin
          state_nxt     = IDLE;
          alarm_cnt_nxt = 8'd0;
          ld            = 1'b1;
        end else if (STOP || START ||
                     (EN1HZ && alarm_cnt == 8'(ALARM_SEC - 1))) begin
          state_nxt     = IDLE;
          alarm_cnt_nxt = 8'd0;
`ifdef CDT_RESTORE_EN
          ld    = 1'b1;
          ld_mh = pre_mh;
          ld_ml = pre_ml;
          ld_sh = pre_sh;
          ld_sl = pre_sl;
`endif
        end else if (EN1HZ) begin
          alarm_cnt_nxt = alarm_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  dcnt60 u_sec (
    .CLK (CLK),
    .RST (RST),
    .LD  (ld),
    .LDH (ld_sh),
    .LDL (ld_sl),
    .INC (sec_inc),
    .DEC (sec_dec),
    .QH  (SH),
    .QL  (SL),
    .BO  (sec_bo)
  );

  dcnt60 u_min (
    .CLK (CLK),
    .RST (RST),
    .LD  (ld),
    .LDH (ld_mh),
    .LDL (ld_ml),
    .INC (min_inc),
    .DEC (sec_bo),
    .QH  (MH),
    .QL  (ML),
    .BO  (min_bo)
  );

endmodule

// File: tb/tb_cdown_timer.sv
// Directed bench for cdown_timer: a vector table for the basic preset/run/
// pause flow, then hand-written sequences for alarm timeout, pause with a
// simultaneous tick, wraparound, borrow chain, async reset and restore.
module tb_cdown_timer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN1HZ = 1'b0, START = 1'b0, STOP = 1'b0, CLR = 1'b0;
  logic       SET_MIN = 1'b0, SET_SEC = 1'b0;
  logic [2:0] MH, SH;
  logic [3:0] ML, SL;
  logic       RUNNING, BUZZ;

  int checks = 0;
  int failures = 0;

  cdown_timer #(.ALARM_SEC(10)) dut (
    .CLK(CLK), .RST(RST), .EN1HZ(EN1HZ), .START(START), .STOP(STOP),
    .CLR(CLR), .SET_MIN(SET_MIN), .SET_SEC(SET_SEC),
    .MH(MH), .ML(ML), .SH(SH), .SL(SL), .RUNNING(RUNNING), .BUZZ(BUZZ)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       start, stop, clr, smin, ssec, tick;
    logic [7:0] m, s;
    logic       run, buzz;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic st, sp, cl, sm, ss, tk,
                              input int m, input int s, input logic run, bz);
    vec_t v;
    v.start = st; v.stop = sp; v.clr = cl; v.smin = sm; v.ssec = ss; v.tick = tk;
    v.m = 8'(m); v.s = 8'(s); v.run = run; v.buzz = bz;
    return v;
  endfunction

  // One clock with the given one-cycle pulses; returns at posedge+1.
  task automatic step(input logic st, sp, cl, sm, ss, tk);
    START = st; STOP = sp; CLR = cl; SET_MIN = sm; SET_SEC = ss; EN1HZ = tk;
    @(posedge CLK);
    #1;
    START = 0; STOP = 0; CLR = 0; SET_MIN = 0; SET_SEC = 0; EN1HZ = 0;
  endtask

  task automatic chk(input string name, input int m, input int s,
                     input logic run, input logic bz);
    logic [15:0] got, exp;
    got = {MH, ML, SH, SL, RUNNING, BUZZ};
    exp = {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), run, bz};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d%0d:%0d%0d run=%b buzz=%b, expected %02d:%02d run=%b buzz=%b",
               name, MH, ML, SH, SL, RUNNING, BUZZ, m, s, run, bz);
    end
  endtask

  initial begin
    //                start stop clr smin ssec tick   m  s  run buzz
    vecs[0]  = mk(0, 0, 0, 1, 0, 0,  1,  0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 0, 0,  2,  0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 0,  3,  0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 1, 0,  3,  1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 1, 0,  3,  2, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 1, 0,  3,  3, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 1, 0,  3,  4, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 1, 0,  3,  5, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1,  3,  5, 0, 0);  // tick in IDLE ignored
    vecs[9]  = mk(1, 0, 0, 0, 0, 0,  3,  5, 1, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 1,  3,  4, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 1,  3,  3, 1, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 1,  3,  2, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 1,  3,  1, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 1,  3,  0, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 1,  2, 59, 1, 0);  // borrow into minutes
    vecs[16] = mk(0, 0, 0, 0, 1, 0,  2, 59, 1, 0);  // SET in RUN ignored
    vecs[17] = mk(0, 1, 0, 0, 0, 0,  2, 59, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 1,  2, 59, 0, 0);  // tick in PAUSE ignored
    vecs[19] = mk(1, 0, 0, 0, 0, 0,  2, 59, 1, 0);
    vecs[20] = mk(0, 0, 1, 0, 0, 0,  0,  0, 0, 0);
    vecs[21] = mk(1, 0, 0, 0, 0, 0,  0,  0, 0, 0);  // START at 00:00 ignored
    vecs[22] = mk(0, 0, 0, 1, 1, 0,  1,  1, 0, 0);  // both set pulses
    vecs[23] = mk(1, 0, 1, 0, 0, 0,  0,  0, 0, 0);  // CLR beats START

    // Reset state
    #12;
    chk("reset", 0, 0, 0, 0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("after_reset", 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].start, vecs[i].stop, vecs[i].clr, vecs[i].smin, vecs[i].ssec, vecs[i].tick);
      chk($sformatf("vec%0d", i), int'(vecs[i].m), int'(vecs[i].s), vecs[i].run, vecs[i].buzz);
    end

    // Seconds wrap 59 -> 00 without carry into minutes
    for (int i = 0; i < 59; i++) step(0, 0, 0, 0, 1, 0);
    chk("sec_59", 0, 59, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("sec_wrap", 0, 0, 0, 0);

    // Alarm entry and timeout after ALARM_SEC ticks
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("alm_start", 0, 2, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("alm_0001", 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("alm_enter", 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 1);
    chk("alm_9ticks", 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("alm_timeout", 0, 0, 0, 0);

    // Pause with simultaneous tick at 01:30
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("p_run", 1, 30, 1, 0);
    step(0, 1, 0, 0, 0, 1);
    chk("p_stop_tick", 1, 30, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    chk("p_hold", 1, 30, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("p_resume", 1, 30, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("p_tick", 1, 29, 1, 0);

    // Full borrow chain 10:00 -> 09:59
    step(0, 0, 1, 0, 0, 0);
    chk("clr_run", 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("borrow_chain", 9, 59, 1, 0);

    // Asynchronous reset mid-cycle
    step(0, 0, 0, 0, 0, 1);
    #3;
    RST = 1'b0;
    #1;
    chk("async_reset", 0, 0, 0, 0);
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Alarm exit by STOP: preset restored only when the feature is built in
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    chk("rst_alarm", 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
`ifdef CDT_RESTORE_EN
    chk("restore", 0, 3, 0, 0);
`else
    chk("restore", 0, 0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
